// File: rtl/rom_read_arbiter.sv
// -----------------------------------------------------------------------------
// rom_read_arbiter
//
// Shares one asynchronous, read-only lookup ROM between two independent
// requesters. An idle cycle arbitrates between the pending requests, latches
// the winner's address into a register that drives the ROM, and acknowledges
// the winner. The following cycle (READ) captures the ROM word and returns it
// to the winner with a one-cycle valid pulse. One read completes every two
// cycles.
//
// Build option:
//   ROM_READ_ARBITER_FIXED_PRIO_EN  defined   -> port 0 always wins a tie
//                                   undefined -> round-robin between ports
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   req0/req1  in   read request, held with a stable address until ack
//   addr0/1    in   read address
//   ack0/1     out  one-cycle pulse: request accepted, address latched
//   rdata0/1   out  read data, holds last returned word
//   rvalid0/1  out  one-cycle pulse: rdata updated this cycle
//   rom_addr   out  registered ROM address
//   rom_data   in   combinational ROM read data
//   busy       out  high while a read is in flight (not IDLE)
// -----------------------------------------------------------------------------
module rom_read_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  rvalid0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  rvalid1,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] READ = 1'b1;

  logic [0:0]            state;
  logic                  gnt;
  logic                  win_valid;
  logic                  win_port;
  logic [ADDR_WIDTH-1:0] win_addr;

`ifndef ROM_READ_ARBITER_FIXED_PRIO_EN
  // Port that was served most recently; resets to 1 so port 0 wins the
  // first tie after reset.
  logic                  last_grant;
`endif

  // Arbitration: a lone request always wins; a tie is broken either by
  // fixed priority to port 0 or by handing the grant to the port that was
  // not served last.
  always_comb begin
    win_valid = req0 | req1;
`ifdef ROM_READ_ARBITER_FIXED_PRIO_EN
    win_port  = req0 ? 1'b0 : 1'b1;
`else
    if (req0 && req1) begin
      win_port = ~last_grant;
    end else begin
      win_port = req0 ? 1'b0 : 1'b1;
    end
`endif
    win_addr = win_port ? addr1 : addr0;
  end

  // Sequencer: IDLE latches the winner and acks it; READ samples the ROM
  // (whose address has been stable since the start of the cycle) and
  // returns the word. rvalid is a pulse, so it is cleared every cycle
  // unless READ is finishing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      rom_addr   <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
`ifndef ROM_READ_ARBITER_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            rom_addr <= win_addr;
            gnt      <= win_port;
            ack0     <= ~win_port;
            ack1     <= win_port;
            state    <= READ;
          end
        end
        READ: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (gnt) begin
            rdata1  <= rom_data;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= rom_data;
            rvalid0 <= 1'b1;
          end
`ifndef ROM_READ_ARBITER_FIXED_PRIO_EN
          last_grant <= gnt;
`endif
          state <= IDLE;
        end
        default: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rom_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_read_arbiter
//
// Bench for rom_read_arbiter with a ROM where rom[a] = a[1:0]. A transaction
// scheduler predicts, from the request lines seen before each edge, when an
// ack and the matching read-data pulse must appear and which port and data
// they carry. Directed scenarios are followed by a randomized phase.
// Honours ROM_READ_ARBITER_FIXED_PRIO_EN for the tie-break expectation.
// -----------------------------------------------------------------------------
module tb_rom_read_arbiter;

  localparam int AW = 3;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1, rom_addr;
  logic [DW-1:0] rdata0, rdata1, rom_data;
  logic          ack0, ack1, rvalid0, rvalid1, busy;

  int total = 0;
  int bad   = 0;

  // Scheduler state: cycle index of the next expected ack and data pulse.
  int            cyc = 0;
  int            ackCyc = -1;
  int            rvCyc = -1;
  bit            ackPort, rvPort;
  bit            lastG = 1'b1;
  logic [1:0]    rvData;
  logic [AW-1:0] pendRom;
  logic [AW-1:0] expRom = '0;
  logic [DW-1:0] expRd0 = '0, expRd1 = '0;
  bit            autoDrop0 = 1'b1, autoDrop1 = 1'b1;
  bit            sawAck0, sawAck1;
  bit            logAcks = 1'b0;
  int            ackLog[$];

  always #5 clk = ~clk;

  assign rom_data = rom_addr[1:0];

  rom_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .ack0(ack0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .addr1(addr1), .ack1(ack1), .rdata1(rdata1), .rvalid1(rvalid1),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic [AW-1:0] a0,
                               input logic r1, input logic [AW-1:0] a1);
    req0  = r0;
    addr0 = a0;
    req1  = r1;
    addr1 = a1;
  endtask

  function automatic bit pickWinner();
    if (req0 && req1) begin
`ifdef ROM_READ_ARBITER_FIXED_PRIO_EN
      return 1'b0;
`else
      return ~lastG;
`endif
    end
    return req0 ? 1'b0 : 1'b1;
  endfunction

  // One clock: schedule from the inputs about to be sampled, advance, then
  // compare every output with the schedule.
  task automatic tick();
    bit w;
    if (reset) begin
      ackCyc = -1;
      rvCyc  = -1;
      lastG  = 1'b1;
      expRom = '0;
      expRd0 = '0;
      expRd1 = '0;
    end else if (ackCyc != cyc && (req0 || req1)) begin
      w       = pickWinner();
      ackCyc  = cyc + 1;
      ackPort = w;
      rvCyc   = cyc + 2;
      rvPort  = w;
      pendRom = w ? addr1 : addr0;
      rvData  = pendRom[1:0];
      lastG   = w;
    end
    @(posedge clk);
    #1;
    cyc++;
    sawAck0 = (ackCyc == cyc) && !ackPort;
    sawAck1 = (ackCyc == cyc) && ackPort;
    if (ackCyc == cyc) expRom = pendRom;
    if (rvCyc == cyc) begin
      if (rvPort) expRd1 = rvData;
      else        expRd0 = rvData;
    end
    checkOutput("ack0",     32'(ack0),     32'(sawAck0));
    checkOutput("ack1",     32'(ack1),     32'(sawAck1));
    checkOutput("rvalid0",  32'(rvalid0),  32'((rvCyc == cyc) && !rvPort));
    checkOutput("rvalid1",  32'(rvalid1),  32'((rvCyc == cyc) && rvPort));
    checkOutput("rdata0",   32'(rdata0),   32'(expRd0));
    checkOutput("rdata1",   32'(rdata1),   32'(expRd1));
    checkOutput("rom_addr", 32'(rom_addr), 32'(expRom));
    checkOutput("busy",     32'(busy),     32'(ackCyc == cyc));
    checkOutput("ack_excl", 32'(ack0 & ack1), 32'(0));
    if (logAcks) begin
      if (ack0) ackLog.push_back(0);
      if (ack1) ackLog.push_back(1);
    end
    if (sawAck0 && autoDrop0) req0 = 1'b0;
    if (sawAck1 && autoDrop1) req1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0);
    tick();
    tick();
    reset = 1'b0;

    // Single read on port 0
    applyStimulus(1'b1, 3'd5, 1'b0, '0);
    tick();
    checkOutput("single_ack0", 32'(ack0), 32'(1));
    checkOutput("single_rom_addr", 32'(rom_addr), 32'(5));
    checkOutput("single_busy", 32'(busy), 32'(1));
    tick();
    checkOutput("single_rvalid0", 32'(rvalid0), 32'(1));
    checkOutput("single_rdata0", 32'(rdata0), 32'(1));
    checkOutput("single_busy_done", 32'(busy), 32'(0));

    // Contention straight out of reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b1, 3'd6, 1'b1, 3'd3);
    tick();
    checkOutput("cont_first_ack0", 32'(ack0), 32'(1));
    tick();
    checkOutput("cont_rdata0", 32'(rdata0), 32'(2));
    tick();
    checkOutput("cont_second_ack1", 32'(ack1), 32'(1));
    tick();
    checkOutput("cont_rvalid1", 32'(rvalid1), 32'(1));
    checkOutput("cont_rdata1", 32'(rdata1), 32'(3));

    // Continuous contention for 8 grants
    autoDrop0 = 1'b0;
    autoDrop1 = 1'b0;
    logAcks   = 1'b1;
    applyStimulus(1'b1, 3'd1, 1'b1, 3'd6);
    for (int i = 0; i < 15; i++) tick();
    applyStimulus(1'b0, 3'd1, 1'b0, 3'd6);
    tick();
    tick();
    logAcks   = 1'b0;
    autoDrop0 = 1'b1;
    checkOutput("fair_count", 32'(ackLog.size()), 32'(8));
    for (int i = 0; i < ackLog.size(); i++) begin
`ifdef ROM_READ_ARBITER_FIXED_PRIO_EN
      checkOutput("fair_order", 32'(ackLog[i]), 32'(0));
`else
      checkOutput("fair_order", 32'(ackLog[i]), 32'(i % 2));
`endif
    end

    // Back-to-back reads on port 1 with a changing address
    applyStimulus(1'b0, '0, 1'b1, 3'd2);
    tick();
    addr1 = 3'd7;
    tick();
    checkOutput("b2b_rvalid1_a", 32'(rvalid1), 32'(1));
    checkOutput("b2b_rdata1_a", 32'(rdata1), 32'(2));
    tick();
    req1 = 1'b0;
    tick();
    checkOutput("b2b_rvalid1_b", 32'(rvalid1), 32'(1));
    checkOutput("b2b_rdata1_b", 32'(rdata1), 32'(3));
    autoDrop1 = 1'b1;

    // Reset in the READ cycle, after port 0 was the last served
    applyStimulus(1'b1, 3'd1, 1'b0, '0);
    tick();
    tick();
    checkOutput("pre_reset_rdata0", 32'(rdata0), 32'(1));
    applyStimulus(1'b1, 3'd1, 1'b0, '0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midrst_rvalid0", 32'(rvalid0), 32'(0));
    checkOutput("midrst_rdata0", 32'(rdata0), 32'(0));
    checkOutput("midrst_busy", 32'(busy), 32'(0));
    applyStimulus(1'b1, 3'd3, 1'b1, 3'd5);
    tick();
    checkOutput("midrst_next_ack0", 32'(ack0), 32'(1));
    for (int i = 0; i < 4; i++) tick();

    // Idle hold after a read of address 4
    applyStimulus(1'b1, 3'd4, 1'b0, '0);
    tick();
    tick();
    for (int i = 0; i < 10; i++) tick();
    checkOutput("idle_rom_addr", 32'(rom_addr), 32'(4));
    checkOutput("idle_rdata0", 32'(rdata0), 32'(0));
    checkOutput("idle_busy", 32'(busy), 32'(0));

    // Randomized requesters obeying the hold-until-ack rule
    for (int i = 0; i < 400; i++) begin
      tick();
      if (sawAck0) begin
        if ($urandom_range(1, 0) == 1) begin
          req0  = 1'b1;
          addr0 = AW'($urandom_range(7, 0));
        end
      end else if (!req0 && $urandom_range(2, 0) == 0) begin
        req0  = 1'b1;
        addr0 = AW'($urandom_range(7, 0));
      end
      if (sawAck1) begin
        if ($urandom_range(1, 0) == 1) begin
          req1  = 1'b1;
          addr1 = AW'($urandom_range(7, 0));
        end
      end else if (!req1 && $urandom_range(2, 0) == 0) begin
        req1  = 1'b1;
        addr1 = AW'($urandom_range(7, 0));
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (!(ackCyc == cyc + 1)) begin
        if (!sawAck0 && i > 2) req0 = 1'b0;
        if (!sawAck1 && i > 2) req1 = 1'b0;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
